// File: rtl/counter_bank.sv
// Bank of independent up/down counters sharing one programmable prescaler.
// Each channel supports clear/load/step pulses, wrap or saturate limits,
// a sticky overflow flag and edge-type zero/compare hit pulses.

module counter_bank_ch #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             autocount,
  input  logic             saturate,
  input  logic             clear,
  input  logic             load,
  input  logic             up,
  input  logic             down,
  input  logic             ovf_clr,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] cmp_value,
  output logic [WIDTH-1:0] count,
  output logic             zero_hit,
  output logic             cmp_hit,
  output logic             ovf
);

  logic             inc, dec;
  logic             at_max, at_min, ovf_evt;
  logic             m_z, m_c, m_z_d, m_c_d;
  logic [WIDTH-1:0] nxt;

  assign at_max  = &count;
  assign at_min  = (count == '0);
  assign ovf_evt = (inc && at_max) || (dec && at_min);
  assign m_z     = at_min;
  assign m_c     = (count == cmp_value);

  // Resolve the single step direction; clear/load suppress all stepping.
  always_comb begin
    inc = 1'b0;
    dec = 1'b0;
    if (!clear && !load) begin
      if (up)                     inc = 1'b1;
      else if (down)              dec = 1'b1;
      else if (autocount && tick) inc = 1'b1;
    end
  end

  // Next count: fixed priority clear > load > inc > dec; limits wrap or hold.
  always_comb begin
    nxt = count;
    if (clear)     nxt = '0;
    else if (load) nxt = load_value;
    else if (inc)  nxt = (at_max && saturate) ? count : count + WIDTH'(1);
    else if (dec)  nxt = (at_min && saturate) ? count : count - WIDTH'(1);
  end

  // Count, sticky overflow and hit-edge registers. History regs reset to 1
  // so a freshly reset (zero) count does not fire a hit pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      count    <= '0;
      ovf      <= 1'b0;
      m_z_d    <= 1'b1;
      m_c_d    <= 1'b1;
      zero_hit <= 1'b0;
      cmp_hit  <= 1'b0;
    end else begin
      count    <= nxt;
      if (ovf_evt)      ovf <= 1'b1;
      else if (ovf_clr) ovf <= 1'b0;
      m_z_d    <= m_z;
      m_c_d    <= m_c;
      zero_hit <= m_z & ~m_z_d;
      cmp_hit  <= m_c & ~m_c_d;
    end
  end

endmodule

module counter_bank #(
  parameter int N_CH  = 4,
  parameter int WIDTH = 16,
  parameter int DIV_W = 24
) (
  input  logic                  ti_clk,
  input  logic                  reset,
  input  logic [DIV_W-1:0]      div_value,
  input  logic [N_CH-1:0]       autocount,
  input  logic [N_CH-1:0]       saturate,
  input  logic [N_CH-1:0]       clear,
  input  logic [N_CH-1:0]       load,
  input  logic [N_CH-1:0]       up,
  input  logic [N_CH-1:0]       down,
  input  logic [N_CH-1:0]       ovf_clr,
  input  logic [N_CH*WIDTH-1:0] load_value,
  input  logic [N_CH*WIDTH-1:0] cmp_value,
  output logic [N_CH*WIDTH-1:0] count,
  output logic                  tick,
  output logic [N_CH-1:0]       zero_hit,
  output logic [N_CH-1:0]       cmp_hit,
  output logic [N_CH-1:0]       ovf
);

  logic [DIV_W-1:0] presc;

  // Prescaler: count down, reload at zero and raise tick for one cycle.
  // A new divisor is only picked up on reload.
  always_ff @(posedge ti_clk) begin
    if (reset) begin
      presc <= div_value;
      tick  <= 1'b0;
    end else if (presc == '0) begin
      presc <= div_value;
      tick  <= 1'b1;
    end else begin
      presc <= presc - DIV_W'(1);
      tick  <= 1'b0;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    counter_bank_ch #(.WIDTH(WIDTH)) u_ch (
      .clk        (ti_clk),
      .reset      (reset),
      .tick       (tick),
      .autocount  (autocount[i]),
      .saturate   (saturate[i]),
      .clear      (clear[i]),
      .load       (load[i]),
      .up         (up[i]),
      .down       (down[i]),
      .ovf_clr    (ovf_clr[i]),
      .load_value (load_value[i*WIDTH +: WIDTH]),
      .cmp_value  (cmp_value[i*WIDTH +: WIDTH]),
      .count      (count[i*WIDTH +: WIDTH]),
      .zero_hit   (zero_hit[i]),
      .cmp_hit    (cmp_hit[i]),
      .ovf        (ovf[i])
    );
  end

endmodule
